// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared selection-mode and output-buffer state types for chan_mux_arbiter.
package chan_mux_pkg;
    typedef enum logic [1:0] {MODE_MAN, MODE_PRIO, MODE_RR, MODE_RSVD} mode_t;
    typedef enum logic {EMPTY, FULL} buf_state_t;
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational channel picker for manual, fixed-priority and round-robin modes.
module rr_grant
    import chan_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [SEL_W-1:0] i_rr_ptr,
    input  logic [1:0]       i_mode,
    input  logic [SEL_W-1:0] i_man_sel,
    output logic [SEL_W-1:0] o_grant,
    output logic             o_grant_valid
);
    localparam int NP = 1 << SEL_W;
    logic [NP-1:0]   w_req_ext;
    logic [N_CH-1:0] w_rot;
    // zero-extended so an out-of-range manual index reads as "not requesting"
    assign w_req_ext = NP'(i_req);
    assign w_rot     = N_CH'({i_req, i_req} >> i_rr_ptr);
    always_comb begin
        o_grant       = '0;
        o_grant_valid = 1'b0;
        if (mode_t'(i_mode) == MODE_PRIO) begin
            for (int k = N_CH - 1; k >= 0; k--)
                if (i_req[k]) begin
                    o_grant       = SEL_W'(k);
                    o_grant_valid = 1'b1;
                end
        end else if (mode_t'(i_mode) == MODE_RR) begin
            for (int k = N_CH - 1; k >= 0; k--)
                if (w_rot[k]) begin
                    o_grant       = SEL_W'((int'(i_rr_ptr) + k) % N_CH);
                    o_grant_valid = 1'b1;
                end
        end else begin
            o_grant       = i_man_sel;
            o_grant_valid = w_req_ext[i_man_sel];
        end
    end
endmodule

// File: rtl/chan_mux_arbiter.sv
// chan_mux_arbiter: N-channel to 1 valid/ready mux with registered, source-tagged output.
module chan_mux_arbiter
    import chan_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  man_sel,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    input  logic              out_ready
);
    buf_state_t       r_state, w_state_nxt;
    logic [SEL_W-1:0] r_rr_ptr, r_ch, w_grant;
    logic [W-1:0]     r_data, w_sel_data;
    logic             w_grant_valid, w_load_ok, w_xfer;

    rr_grant #(.N_CH(N_CH), .SEL_W(SEL_W)) u_grant (
        .i_req         (in_valid),
        .i_rr_ptr      (r_rr_ptr),
        .i_mode        (mode),
        .i_man_sel     (man_sel),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    assign w_load_ok = (r_state == EMPTY) | out_ready;
    assign w_xfer    = w_load_ok & w_grant_valid & ~rst;
    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_ch    = r_ch;

    always_comb begin
        in_ready   = '0;
        w_sel_data = '0;
        for (int k = 0; k < N_CH; k++)
            if (w_grant == SEL_W'(k)) begin
                in_ready[k] = w_xfer;
                w_sel_data  = in_data[k*W +: W];
            end
    end

    always_comb begin
        w_state_nxt = w_xfer ? FULL : (r_state == FULL && !out_ready) ? FULL : EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_data   <= '0;
            r_ch     <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_data <= w_sel_data;
                r_ch   <= w_grant;
            end
            if (w_xfer && mode_t'(mode) == MODE_RR)
                r_rr_ptr <= (int'(w_grant) == N_CH - 1) ? '0 : w_grant + 1'b1;
        end
    end
endmodule

// File: tb/tb_chan_mux_arbiter.sv
// tb_chan_mux_arbiter: scoreboard bench for the 4x8 arbiter plus a 3x16 instance for range checks.
module tb_chan_mux_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = '0;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [1:0]  mode = 2'd0;
    logic [1:0]  man_sel = 2'd0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready = 1'b0;
    logic [7:0]  d [4];

    logic [2:0]  b_in_valid = '0;
    logic [47:0] b_in_data = {16'h3333, 16'h2222, 16'h1111};
    logic [2:0]  b_in_ready;
    logic [1:0]  b_mode = 2'd0;
    logic [1:0]  b_man_sel = 2'd3;
    logic        b_out_valid;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_ch;
    logic        b_out_ready = 1'b1;

    int n_chk = 0;
    int n_pass = 0;
    logic [9:0] q[$];

    always #5 clk = ~clk;
    assign in_data = {d[3], d[2], d[1], d[0]};

    chan_mux_arbiter #(.N_CH(4), .W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mode(mode), .man_sel(man_sel), .out_valid(out_valid), .out_data(out_data),
        .out_ch(out_ch), .out_ready(out_ready)
    );

    chan_mux_arbiter #(.N_CH(3), .W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .mode(b_mode), .man_sel(b_man_sel), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_ready(b_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int data);
        q.push_back({2'(ch), 8'(data)});
    endtask

    task automatic drain(input string tag);
        in_valid  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        tick();
        check(tag, q.size(), 0);
        check({tag, "_idle"}, out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) check("unexpected_word", {out_ch, out_data}, 10'h3ff);
            else check("sb_word", {out_ch, out_data}, q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) d[k] = 8'(8'h10 + k);
        in_valid = 4'b1111;
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        // manual sweep
        for (int s = 0; s < 4; s++) begin
            man_sel = 2'(s);
            push(s, 8'h10 + s);
            tick();
        end
        man_sel = 2'd2;
        in_valid = 4'b1011;
        @(negedge clk);
        check("man_novalid_ready", in_ready, 0);
        tick();
        @(negedge clk);
        check("man_novalid_drop", out_valid, 0);
        drain("man_drain");
        // fixed priority
        mode = 2'd1;
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            push(1, 8'h11);
            @(negedge clk);
            check("prio_ready", in_ready, 4'b0010);
            tick();
        end
        in_valid = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            push(3, 8'h13);
            tick();
        end
        drain("prio_drain");
        // round robin
        mode = 2'd2;
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            push(i % 4, 8'h10 + i % 4);
            tick();
        end
        drain("rr_drain");
        // backpressure
        mode = 2'd0;
        man_sel = 2'd0;
        d[0] = 8'hA5;
        in_valid = 4'b0001;
        out_ready = 1'b0;
        push(0, 8'hA5);
        tick();
        d[0] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 8'hA5);
            check("bp_ch", out_ch, 0);
            check("bp_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        push(0, 8'h5A);
        @(negedge clk);
        check("b2b_ready", in_ready, 4'b0001);
        tick();
        in_valid = '0;
        @(negedge clk);
        check("b2b_valid", out_valid, 1);
        check("b2b_data", out_data, 8'h5A);
        drain("bp_drain");
        d[0] = 8'h10;
        // reset mid-operation with rr_ptr at 2
        mode = 2'd2;
        in_valid = 4'b0010;
        push(1, 8'h11);
        tick();
        in_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_held", {out_valid, out_ch}, 3'b101);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_ch", out_ch, 0);
        q.delete();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 0);
        push(0, 8'h10);
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        push(1, 8'h11);
        tick();
        drain("rst_drain");
        // reserved mode behaves as manual
        mode = 2'd3;
        man_sel = 2'd1;
        in_valid = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            push(1, 8'h11);
            tick();
        end
        drain("rsvd_drain");
        // 3-channel instance: index 3 is out of range
        b_in_valid = 3'b111;
        @(negedge clk);
        check("n3_oob_ready", b_in_ready, 0);
        tick();
        tick();
        @(negedge clk);
        check("n3_oob_valid", b_out_valid, 0);
        b_mode = 2'd3;
        @(negedge clk);
        check("n3_rsvd_oob_ready", b_in_ready, 0);
        b_mode = 2'd0;
        b_man_sel = 2'd2;
        @(negedge clk);
        check("n3_sel2_ready", b_in_ready, 3'b100);
        tick();
        @(negedge clk);
        check("n3_sel2_valid", b_out_valid, 1);
        check("n3_sel2_ch", b_out_ch, 2);
        check("n3_sel2_data", b_out_data, 16'h3333);
        b_in_valid = '0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/chan_mux_arbiter.md
Name: chan_mux_arbiter

Overview:
Parametrised N-channel to 1 multiplexer. It generalises the 4-to-1 select mux to N_CH channels of W-bit data, with a registered output and valid/ready handshakes on every input and on the output. Three selection modes are supported: manual select (the classic mux behaviour), fixed priority, and round-robin. The block sits between several producer channels and a single consumer, and tags each output word with its source channel.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SEL_W, $clog2(N_CH), width of the channel index (derived, not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, N_CH, per-channel "data valid".
- in_data, input, N_CH*W, packed channel data; channel k occupies bits [k*W +: W].
- in_ready, output, N_CH, per-channel accept, one-hot or zero (combinational).
- mode, input, 2, selection mode:
  - 00 = manual
  - 01 = fixed priority, channel 0 highest
  - 10 = round-robin
  - 11 = treated as manual
- man_sel, input, SEL_W, channel index used in manual mode.
- out_valid, output, 1, output register holds a word.
- out_data, output, W, registered selected data.
- out_ch, output, SEL_W, source channel of out_data.
- out_ready, input, 1, consumer accepts the word.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer rr_ptr=0; buffer state EMPTY.
  - in_ready=0 while rst is high.
- Output buffer FSM, two states:
  - EMPTY (out_valid=0) -> FULL on an accepted input.
  - FULL (out_valid=1):
    - Goes to EMPTY when out_ready=1 and no input is accepted.
    - Stays FULL when out_ready=1 and an input is accepted in the same cycle (back-to-back transfer).
    - Stays FULL with out_data and out_ch held stable while out_ready=0.
- load_ok = (state==EMPTY) | out_ready.
- Grant, combinational, at most one channel:
  - Manual: grant = man_sel if in_valid[man_sel]=1 and man_sel < N_CH; otherwise no grant.
  - Fixed priority: the lowest-index channel with valid=1.
  - Round-robin: the first channel with valid=1 searching rr_ptr, rr_ptr+1, ... mod N_CH.
- in_ready[g] = load_ok & grant_valid & (g == grant); all other bits are 0.
- A transfer on channel g happens when in_valid[g] & in_ready[g]. At the next edge:
  - out_data = in_data[g], out_ch = g, out_valid = 1.
  - Latency is 1 cycle from input transfer to out_valid.
- rr_ptr update: only on a transfer in round-robin mode, set rr_ptr = (g+1) mod N_CH, wrapping N_CH-1 -> 0. rr_ptr is held in other modes and when no transfer occurs.
- Mode or man_sel changes take effect on the next grant decision. A word already held in the output register is never altered.
- No valid inputs: no grant; the FSM drains normally.
- Simultaneous input and output transfers in one cycle: both complete, and out_valid stays 1 with the new word.
- Reset asserted mid-transfer: the held word is discarded, and all outputs and rr_ptr return to their reset values immediately.
- Protocol expectations on producers:
  - Producers hold in_data stable while in_valid=1 and in_ready=0.
  - The block does not require in_valid to stay high.

Decomposition:
- Package chan_mux_pkg:
  - Mode typedef enum logic[1:0] {MODE_MAN, MODE_PRIO, MODE_RR, MODE_RSVD}.
  - Buffer state typedef enum {EMPTY, FULL}.
- Sub-module rr_grant, combinational. Parameter N_CH. Inputs: request vector, rr_ptr, mode, man_sel. Outputs: grant index and grant_valid.
- The top module holds the FSM, the output register and rr_ptr.

Test Plan:
1. Manual sweep: mode=00, out_ready=1, all in_valid=1, data = 8'h10 + k; step man_sel 0..3 -> out_data 10, 11, 12, 13 with out_ch 0..3, each one cycle after selection. With man_sel=2 and in_valid[2]=0 -> in_ready=0 and out_valid drops.
2. Fixed priority: mode=01, in_valid=4'b1010 -> channel 1 granted repeatedly (out_ch=1 every cycle); clear in_valid[1] -> out_ch=3.
3. Round-robin fairness: mode=10, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with rr_ptr wrapping 3 -> 0.
4. Backpressure: FULL with out_data=8'hA5, hold out_ready=0 for 3 cycles -> out_data and out_ch stable and in_ready=0. Raise out_ready -> back-to-back transfer, out_valid stays 1 with the new word.
5. Reset mid-operation: assert rst asynchronously while out_valid=1 and rr_ptr=2 -> out_valid, out_data and out_ch are 0 immediately; after release the first round-robin grant goes to channel 0.
6. Reserved mode: mode=11, man_sel=1 -> behaves identically to manual (out_ch=1). Also run with parameters N_CH=3, W=16 and man_sel=3 -> no grant.
